// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } sub_state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_sub_1b.sv
// Gate-level full subtractor cell: d = a ^ b ^ bin, bout = ~a&b | ~a&bin | b&bin.
module serial_subtractor_sub_1b (
    input  logic      a,
    input  logic      b,
    input  logic      bin,
    output wire logic bout,
    output wire logic d
);

    wire w_na;
    wire w_axb;
    wire w_t0;
    wire w_t1;
    wire w_t2;

    not u_not_a  (w_na, a);
    xor u_xor_ab (w_axb, a, b);
    xor u_xor_d  (d, w_axb, bin);
    and u_and_0  (w_t0, w_na, b);
    and u_and_1  (w_t1, w_na, bin);
    and u_and_2  (w_t2, b, bin);
    or  u_or_b   (bout, w_t0, w_t1, w_t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
// Operands enter on a start valid/ready handshake; the result leaves on a done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    sub_state_e       r_state;
    sub_state_e       w_state_d;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bin;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    wire              w_d;
    wire              w_bout;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_last;

    serial_subtractor_sub_1b u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_bin),
        .bout (w_bout),
        .d    (w_d)
    );

    // New bit enters at the MSB so the result is aligned once all WIDTH bits are in.
    if (WIDTH == 1) begin : g_w1
        assign w_diff_next = w_d;
    end else begin : g_wn
        assign w_diff_next = {w_d, r_diff_sh[WIDTH-1:1]};
    end

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (start_valid) w_state_d = StShift;
            StShift: if (w_last)      w_state_d = StDone;
            StDone:  if (done_ready)  w_state_d = StIdle;
            default:                  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_cnt     <= '0;
            r_bin     <= 1'b0;
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                    end
                end
                StShift: begin
                    r_diff_sh <= w_diff_next;
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_bin     <= w_bout;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // w_d is the result MSB on the final bit.
                        r_diff   <= w_diff_next;
                        r_borrow <= w_bout;
                        r_ovf    <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                        r_zero   <= (w_diff_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (r_state == StIdle);
    assign busy        = (r_state == StShift);
    assign done_valid  = (r_state == StDone);
    assign diff        = r_diff;
    assign borrow      = r_borrow;
    assign ovf         = r_ovf;
    assign zero        = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8: vector table plus handshake/reset sequences.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        logic         zero;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         done_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         start_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;
    logic         done_valid;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .diff        (diff),
        .borrow      (borrow),
        .ovf         (ovf),
        .zero        (zero),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " diff"}, 32'(diff), 32'h0);
        check({tag, " borrow"}, 32'(borrow), 32'h0);
        check({tag, " ovf"}, 32'(ovf), 32'h0);
        check({tag, " zero"}, 32'(zero), 32'h0);
        check({tag, " done_valid"}, 32'(done_valid), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " start_ready"}, 32'(start_ready), 32'h1);
    endtask

    // Present operands for one cycle; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        @(negedge clk);
        a = ta;
        b = tb_v;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        check("accepted busy", 32'(busy), 32'h1);
    endtask

    // Counts edges after acceptance until done_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        check("after handshake done_valid", 32'(done_valid), 32'h0);
        check("after handshake start_ready", 32'(start_ready), 32'h1);
    endtask

    task automatic check_result(input vec_t v);
        check("diff", 32'(diff), 32'(v.diff));
        check("borrow", 32'(borrow), 32'(v.borrow));
        check("ovf", 32'(ovf), 32'(v.ovf));
        check("zero", 32'(zero), 32'(v.zero));
    endtask

    initial begin
        vec_t vecs[9];
        vec_t v;
        int   lat;
        logic [W-1:0] held;

        vecs[0] = '{a: 8'h5A, b: 8'h23, diff: 8'h37, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
        vecs[1] = '{a: 8'h10, b: 8'h20, diff: 8'hF0, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, ovf: 1'b1, zero: 1'b0};
        vecs[3] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, borrow: 1'b1, ovf: 1'b1, zero: 1'b0};
        vecs[4] = '{a: 8'hC3, b: 8'hC3, diff: 8'h00, borrow: 1'b0, ovf: 1'b0, zero: 1'b1};
        vecs[5] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'h00, diff: 8'hFF, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
        vecs[7] = '{a: 8'h01, b: 8'h80, diff: 8'h81, borrow: 1'b1, ovf: 1'b1, zero: 1'b0};
        vecs[8] = '{a: 8'h00, b: 8'h00, diff: 8'h00, borrow: 1'b0, ovf: 1'b0, zero: 1'b1};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(lat);
            check("latency", 32'(lat), 32'(W));
            check_result(vecs[i]);
            finish_op();
            check("diff held in idle", 32'(diff), 32'(vecs[i].diff));
        end

        // Hold DONE for 5 cycles with new operands offered; nothing may change.
        start_op(8'h10, 8'h20);
        wait_done(lat);
        check("hold latency", 32'(lat), 32'(W));
        held = diff;
        check("hold diff start", 32'(held), 32'hF0);
        @(negedge clk);
        a = 8'h5A;
        b = 8'h23;
        start_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold done_valid", 32'(done_valid), 32'h1);
            check("hold start_ready", 32'(start_ready), 32'h0);
            check("hold diff", 32'(diff), 32'(held));
            check("hold borrow", 32'(borrow), 32'h1);
        end
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        check("same-cycle start not taken busy", 32'(busy), 32'h0);
        check("same-cycle start idle", 32'(start_ready), 32'h1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        check("start taken in idle", 32'(busy), 32'h1);
        wait_done(lat);
        check("post-hold latency", 32'(lat), 32'(W));
        v = '{a: 8'h5A, b: 8'h23, diff: 8'h37, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
        check_result(v);
        finish_op();

        // Leave a borrow=1 result visible so reset clearing is observable.
        start_op(8'h01, 8'h80);
        wait_done(lat);
        finish_op();
        start_op(8'hAA, 8'h55);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-shift reset");
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h01, 8'h02);
        wait_done(lat);
        check("post-reset latency", 32'(lat), 32'(W));
        v = '{a: 8'h01, b: 8'h02, diff: 8'hFF, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};
        check_result(v);
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing a − b LSB-first, one bit per clock, through a single full-subtractor cell and a registered borrow. Operands are accepted on a valid/ready start handshake and the result is presented on a valid/ready done handshake. It is the datapath's area-minimal subtraction unit, the counterpart of the gate-level 1-bit adder used for addition, and it sits beside that adder in the ALU.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  operands a, b presented.
- start_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  minuend; sampled on start handshake.
- b  in  WIDTH  subtrahend; sampled on start handshake.
- diff  out  WIDTH  (a − b) mod 2^WIDTH.
- borrow  out  1  final borrow; 1 iff a < b unsigned.
- ovf  out  1  signed overflow: a[MSB] ≠ b[MSB] and diff[MSB] ≠ a[MSB].
- zero  out  1  diff == 0.
- done_valid  out  1  result valid (high only in DONE).
- done_ready  in  1  consumer accepts result.
- busy  out  1  high in SHIFT.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start_ready=1. start_valid=1 at an edge: load a_sh←a, b_sh←b, bin←0, cnt←0, capture a[MSB], b[MSB]; go to SHIFT.
- SHIFT: cell inputs a_sh[0], b_sh[0], bin. d = a⊕b⊕bin, bout = (~a·b)+(~a·bin)+(b·bin). Each edge: diff_sh shifts right with d into the MSB; a_sh and b_sh shift right; bin←bout; cnt←cnt+1. When cnt==WIDTH−1, go to DONE and latch borrow←bout, ovf, zero from the completed value.
- DONE: done_valid=1. diff, borrow, ovf and zero are held stable. done_ready=1 at an edge: go to IDLE; outputs hold their values until the next result.
- a and b are ignored outside the IDLE handshake. start_valid in SHIFT or DONE is ignored (start_ready=0).
- cnt width: clog2(WIDTH)+1. Wrap-around is impossible because cnt is cleared on load.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, diff=0, borrow=0, ovf=0, zero=0, done_valid=0, busy=0, start_ready=1.
- Latency: start accepted at edge E. done_valid is high after edge E+WIDTH, for WIDTH=1 after E+1. Throughput is one operation per WIDTH+2 cycles minimum.
- DONE→IDLE always costs one cycle. done_ready and start_valid high in the same DONE cycle do not start a new operation; the start is accepted in the following IDLE cycle.
- done_ready is ignored outside DONE.
- Reset asserted mid-SHIFT or in DONE aborts the operation. The next operation after reset produces a correct result.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.

## Structure
- Shared header (sub_defs.vh): state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2, and the default WIDTH.
- One sub-module, sub_1b (a, b, bin, bout, d): a gate-level full subtractor built from primitive and/or/not/xor, mirroring the 1-bit adder cell.
- The top level holds the FSM, the counter and the shift registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x23 → diff=0x37, borrow=0, ovf=0, zero=0; done_valid rises exactly 8 edges after acceptance.
- a=0x10, b=0x20 → diff=0xF0, borrow=1, ovf=0.
- a=0x80, b=0x01 → diff=0x7F, ovf=1, borrow=0; a=0x7F, b=0xFF → diff=0x80, ovf=1, borrow=1.
- a=b=0xC3 → diff=0x00, zero=1, borrow=0.
- done_ready held low 5 cycles → outputs stable and start_valid ignored. Handshake, then start_valid held high → accepted one cycle later in IDLE.
- rst_n pulsed low during bit 4 of SHIFT → all outputs at reset values without waiting for a clock edge. Next operation a=0x01, b=0x02 → diff=0xFF, borrow=1.
